// File: rtl/tap_pkg.sv
// Shared JTAG definitions: TAP state encoding, IR opcodes and master command opcodes.
// Used by the TAP master and by the TAP target.
package tap_pkg;

  // IEEE 1149.1 controller states, 0..15
  typedef enum logic [3:0] {
    TapTlr      = 4'd0,
    TapIdle     = 4'd1,
    TapSelDr    = 4'd2,
    TapCapDr    = 4'd3,
    TapShiftDr  = 4'd4,
    TapExit1Dr  = 4'd5,
    TapPauseDr  = 4'd6,
    TapExit2Dr  = 4'd7,
    TapUpdateDr = 4'd8,
    TapSelIr    = 4'd9,
    TapCapIr    = 4'd10,
    TapShiftIr  = 4'd11,
    TapExit1Ir  = 4'd12,
    TapPauseIr  = 4'd13,
    TapExit2Ir  = 4'd14,
    TapUpdateIr = 4'd15
  } tap_state_e;

  typedef enum logic [1:0] {
    OpRunTest = 2'b00,
    OpIrScan  = 2'b01,
    OpDrScan  = 2'b10,
    OpTapRst  = 2'b11
  } cmd_op_e;

  localparam logic [2:0] IrExtest        = 3'b000;
  localparam logic [2:0] IrSamplePreload = 3'b001;
  localparam logic [2:0] IrIntest        = 3'b010;
  localparam logic [2:0] IrBypass        = 3'b111;

endpackage

// File: rtl/tap_state_mirror.sv
// Mirror of the target TAP controller: next-state function of (state, TMS) plus state register.
module tap_state_mirror
  import tap_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       tms_i,
  output tap_state_e state_o
);

  tap_state_e state_q, state_d;

  // Standard TAP transition table
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      TapTlr:      state_d = tms_i ? TapTlr      : TapIdle;
      TapIdle:     state_d = tms_i ? TapSelDr    : TapIdle;
      TapSelDr:    state_d = tms_i ? TapSelIr    : TapCapDr;
      TapCapDr:    state_d = tms_i ? TapExit1Dr  : TapShiftDr;
      TapShiftDr:  state_d = tms_i ? TapExit1Dr  : TapShiftDr;
      TapExit1Dr:  state_d = tms_i ? TapUpdateDr : TapPauseDr;
      TapPauseDr:  state_d = tms_i ? TapExit2Dr  : TapPauseDr;
      TapExit2Dr:  state_d = tms_i ? TapUpdateDr : TapShiftDr;
      TapUpdateDr: state_d = tms_i ? TapSelDr    : TapIdle;
      TapSelIr:    state_d = tms_i ? TapTlr      : TapCapIr;
      TapCapIr:    state_d = tms_i ? TapExit1Ir  : TapShiftIr;
      TapShiftIr:  state_d = tms_i ? TapExit1Ir  : TapShiftIr;
      TapExit1Ir:  state_d = tms_i ? TapUpdateIr : TapPauseIr;
      TapPauseIr:  state_d = tms_i ? TapExit2Ir  : TapPauseIr;
      TapExit2Ir:  state_d = tms_i ? TapUpdateIr : TapShiftIr;
      TapUpdateIr: state_d = tms_i ? TapSelDr    : TapIdle;
    endcase
  end

  // State register, reset lands in Test-Logic-Reset
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= TapTlr;
    end else begin
      state_q <= state_d;
    end
  end

  assign state_o = state_q;

endmodule

// File: rtl/jtag_tap_master.sv
// JTAG TAP master: turns host scan commands into TMS/TDI sequences, captures TDO.
// Optional: `TAP_MASTER_RST_SEQ_EN enables a TMS=1 reset sequence after TRST release.
module jtag_tap_master
  import tap_pkg::*;
#(
  parameter int unsigned MAX_LEN    = 16,
  parameter int unsigned LEN_W      = $clog2(MAX_LEN + 1),
  parameter int unsigned IR_LEN     = 3,
  parameter int unsigned RST_CYCLES = 5
) (
  input  logic               TCK,
  input  logic               TRST,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_op,
  input  logic [LEN_W-1:0]   cmd_len,
  input  logic [MAX_LEN-1:0] cmd_data,
  output logic               resp_valid,
  output logic [MAX_LEN-1:0] resp_data,
  output logic               TMS,
  output logic               TDI,
  input  logic               TDO,
  output logic [3:0]         tap_state
);

  localparam int unsigned IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int unsigned CNT_W = $clog2(MAX_LEN + RST_CYCLES + 2);

  typedef enum logic [2:0] {
    StInit,
    StIdle,
    StRunTest,
    StScan,
    StTapRst
  } ctrl_e;

  ctrl_e              ctrl_q, ctrl_d;
  cmd_op_e            op_q, op_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [MAX_LEN-1:0] data_q, data_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [MAX_LEN-1:0] resp_q, resp_d;
  logic               resp_valid_q, resp_valid_d;

  tap_state_e         mirror_state;
  logic               tms_int, tdi_int;
  logic [LEN_W-1:0]   len_clamp;
  logic [IDX_W-1:0]   bit_idx;
  logic [31:0]        cnt32, len32;
  logic               last_bit;

  tap_state_mirror u_mirror (
    .clk_i   (TCK),
    .rst_i   (TRST),
    .tms_i   (tms_int),
    .state_o (mirror_state)
  );

  assign bit_idx  = cnt_q[IDX_W-1:0];
  assign cnt32    = 32'(cnt_q);
  assign len32    = 32'(len_q);
  assign last_bit = (cnt32 + 32'd1 == len32);

  // Effective length of an incoming command: clamp, and default IR length for IR len 0
  always_comb begin
    len_clamp = cmd_len;
    if (32'(cmd_len) > MAX_LEN) begin
      len_clamp = LEN_W'(MAX_LEN);
    end
    if ((cmd_op == OpIrScan) && (cmd_len == '0)) begin
      len_clamp = LEN_W'(IR_LEN);
    end
  end

  // Controller next state and Moore TMS/TDI decode from registered state
  always_comb begin
    ctrl_d       = ctrl_q;
    op_d         = op_q;
    len_d        = len_q;
    data_d       = data_q;
    cnt_d        = cnt_q;
    resp_d       = resp_q;
    resp_valid_d = 1'b0;
    tms_int      = 1'b0;
    tdi_int      = 1'b0;
    unique case (ctrl_q)
      StInit: begin
`ifdef TAP_MASTER_RST_SEQ_EN
        if (cnt32 < RST_CYCLES) begin
          tms_int = 1'b1;
          cnt_d   = cnt_q + CNT_W'(1);
        end else begin
          ctrl_d = StIdle;
          cnt_d  = '0;
        end
`else
        ctrl_d = StIdle;
`endif
      end
      StIdle: begin
        if (cmd_valid) begin
          op_d   = cmd_op_e'(cmd_op);
          len_d  = len_clamp;
          data_d = cmd_data;
          cnt_d  = '0;
          resp_d = '0;
          unique case (cmd_op_e'(cmd_op))
            OpRunTest: ctrl_d = StRunTest;
            OpIrScan:  ctrl_d = StScan;
            OpDrScan:  ctrl_d = StScan;
            OpTapRst:  ctrl_d = StTapRst;
          endcase
        end
      end
      StRunTest: begin
        if ((len_q == '0) || last_bit) begin
          resp_valid_d = 1'b1;
          ctrl_d       = StIdle;
          cnt_d        = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      StTapRst: begin
        // Hold TMS high until the count is done and the mirror is in Test-Logic-Reset
        if ((cnt32 < RST_CYCLES) || (mirror_state != TapTlr)) begin
          tms_int = 1'b1;
          if (cnt32 < RST_CYCLES) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else begin
          resp_valid_d = 1'b1;
          ctrl_d       = StIdle;
          cnt_d        = '0;
        end
      end
      StScan: begin
        case (mirror_state)
          TapIdle:  tms_int = 1'b1;
          TapSelDr: tms_int = (op_q == OpIrScan);
          TapSelIr: tms_int = 1'b0;
          TapCapDr, TapCapIr: tms_int = (len_q == '0);
          TapShiftDr, TapShiftIr: begin
            tdi_int         = data_q[bit_idx];
            tms_int         = last_bit;
            resp_d[bit_idx] = TDO;
            cnt_d           = cnt_q + CNT_W'(1);
          end
          TapExit1Dr, TapExit1Ir: tms_int = 1'b1;
          TapUpdateDr, TapUpdateIr: begin
            tms_int      = 1'b0;
            resp_valid_d = 1'b1;
            ctrl_d       = StIdle;
            cnt_d        = '0;
          end
          default: tms_int = 1'b1;
        endcase
      end
      default: ctrl_d = StInit;
    endcase
  end

  // Command, counter and response registers
  always_ff @(posedge TCK or posedge TRST) begin
    if (TRST) begin
      ctrl_q       <= StInit;
      op_q         <= OpRunTest;
      len_q        <= '0;
      data_q       <= '0;
      cnt_q        <= '0;
      resp_q       <= '0;
      resp_valid_q <= 1'b0;
    end else begin
      ctrl_q       <= ctrl_d;
      op_q         <= op_d;
      len_q        <= len_d;
      data_q       <= data_d;
      cnt_q        <= cnt_d;
      resp_q       <= resp_d;
      resp_valid_q <= resp_valid_d;
    end
  end

  // TRST forces TMS high even before the controller has a chance to decode it
  assign TMS        = TRST | tms_int;
  assign TDI        = tdi_int;
  assign cmd_ready  = (ctrl_q == StIdle);
  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_q;
  assign tap_state  = mirror_state;

endmodule
